// File: rtl/decode_stage.sv
// Registered NanoMIPS instruction decode stage with valid/ready handshakes,
// a one-bubble load-use interlock, a sticky halt and a saturating retire counter.
//
// state   | meaning
// RUN     | accepting instructions, presenting decoded bundles
// HALT    | a done bundle was taken downstream; frozen until reset
module decode_stage #(
  parameter int RW = 3,
  parameter int DW = 8,
  parameter logic [(2**(RW+1))-1:0] DIR_MASK = 16'hA2AA,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*RW+2:0]      in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RW:0]          alu_opcode,
  output logic [RW-1:0]        rs,
  output logic [RW-1:0]        rt,
  output logic [DW-1:0]        immediate,
  output logic [2:0]           reg_data_source,
  output logic                 reg_write,
  output logic                 reg_direction,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 select_super_reg,
  output logic                 branch_ready,
  output logic                 branch_not_zero,
  output logic                 branch_lut_set,
  output logic [RW-1:0]        branch_index,
  output logic [RW-1:0]        branch_lut_index,
  output logic                 done,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  localparam int IW = 2*RW+3;

  localparam logic [2:0] SRC_ZERO   = 3'd0;
  localparam logic [2:0] SRC_ALU    = 3'd1;
  localparam logic [2:0] SRC_MEM    = 3'd2;
  localparam logic [2:0] SRC_IMM    = 3'd3;
  localparam logic [2:0] SRC_PARITY = 3'd4;

  typedef struct packed {
    logic [RW:0]   alu_opcode;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] immediate;
    logic [2:0]    src;
    logic          reg_write;
    logic          reg_direction;
    logic          mem_read;
    logic          mem_write;
    logic          select_super_reg;
    logic          branch_ready;
    logic          branch_not_zero;
    logic          branch_lut_set;
    logic [RW-1:0] branch_index;
    logic [RW-1:0] branch_lut_index;
    logic          done;
    logic          illegal;
  } bundle_t;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t        state;
  bundle_t       q;
  bundle_t       d;
  logic [1:0]    cls;
  logic [RW-1:0] subop;
  logic          is_misc;
  logic          reads_load_rt;
  logic          hazard;

  assign cls     = in_instr[IW-1:IW-2];
  assign subop   = in_instr[2*RW-1:RW];
  assign is_misc = (cls == 2'b10) && in_instr[IW-3];

  always_comb begin
    d = '0;
    case (cls)
      2'b00: begin
        d.alu_opcode       = in_instr[IW-3:RW];
        d.rt               = in_instr[RW-1:0];
        d.src              = SRC_ALU;
        d.reg_write        = 1'b1;
        d.select_super_reg = 1'b1;
        d.reg_direction    = DIR_MASK[in_instr[IW-3:RW]];
      end
      2'b01: begin
        d.rt = in_instr[2*RW-1:RW];
        d.rs = in_instr[RW-1:0];
        if (!in_instr[IW-3]) begin
          d.mem_read      = 1'b1;
          d.reg_write     = 1'b1;
          d.reg_direction = 1'b1;
          d.src           = SRC_MEM;
        end else begin
          d.mem_write = 1'b1;
        end
      end
      2'b10: begin
        if (!in_instr[IW-3]) begin
          d.branch_ready    = 1'b1;
          d.branch_not_zero = in_instr[2*RW-1];
          d.rs              = {1'b0, in_instr[2*RW-2:RW]};
          d.branch_index    = in_instr[RW-1:0];
        end else if (subop == '1) begin
          d.illegal = 1'b1;
        end else if (subop == RW'(0)) begin
          d.reg_write = 1'b1;
        end else if (subop == RW'(1)) begin
          d.reg_write     = 1'b1;
          d.reg_direction = 1'b1;
          d.rt            = in_instr[RW-1:0];
        end else if (subop == RW'(2)) begin
          d.reg_write  = 1'b1;
          d.alu_opcode = (RW+1)'(1);
          d.src        = SRC_ALU;
          d.rt         = in_instr[RW-1:0];
        end else if (subop == RW'(3)) begin
          d.reg_write     = 1'b1;
          d.reg_direction = 1'b1;
          d.src           = SRC_ALU;
          d.rt            = in_instr[RW-1:0];
        end else if (subop == RW'(4)) begin
          d.reg_write = 1'b1;
          d.src       = SRC_PARITY;
        end else if (subop == RW'(5)) begin
          d.done = 1'b1;
        end else if (subop == RW'(6)) begin
          d.branch_lut_set   = 1'b1;
          d.branch_lut_index = in_instr[RW-1:0];
        end
      end
      2'b11: begin
        d.immediate = DW'(in_instr[IW-3:0]);
        d.src       = SRC_IMM;
        d.reg_write = 1'b1;
      end
    endcase
  end

  // Registers the candidate would read that the held load is about to write.
  always_comb begin
    reads_load_rt = 1'b0;
    if (cls == 2'b00)
      reads_load_rt = (d.rt == q.rt);
    else if (d.mem_write)
      reads_load_rt = (d.rs == q.rt) || (d.rt == q.rt);
    else if (d.branch_ready)
      reads_load_rt = (d.rs == q.rt);
    else if (is_misc && subop == RW'(2))
      reads_load_rt = (d.rt == q.rt);
  end

  assign hazard = in_valid && out_valid && q.mem_read && reads_load_rt;

  // Nothing may follow a done bundle, so intake closes as soon as one is held.
  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready) && !hazard
                    && !(out_valid && q.done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      out_valid <= 1'b0;
      q         <= '0;
      retired   <= '0;
    end else begin
      if (out_valid && out_ready && retired != '1)
        retired <= retired + CNT_W'(1);
      case (state)
        ST_RUN: begin
          if (out_valid && out_ready && q.done) begin
            state     <= ST_HALT;
            out_valid <= 1'b0;
          end else if (in_valid && in_ready) begin
            q         <= d;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

  assign alu_opcode       = q.alu_opcode;
  assign rs               = q.rs;
  assign rt               = q.rt;
  assign immediate        = q.immediate;
  assign reg_data_source  = q.src;
  assign reg_write        = q.reg_write;
  assign reg_direction    = q.reg_direction;
  assign mem_read         = q.mem_read;
  assign mem_write        = q.mem_write;
  assign select_super_reg = q.select_super_reg;
  assign branch_ready     = q.branch_ready;
  assign branch_not_zero  = q.branch_not_zero;
  assign branch_lut_set   = q.branch_lut_set;
  assign branch_index     = q.branch_index;
  assign branch_lut_index = q.branch_lut_index;
  assign done             = q.done;
  assign illegal          = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, stream, load-use bubbles,
// backpressure, counter saturation and halt.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_opcode;
  logic [2:0]  rs, rt;
  logic [7:0]  immediate;
  logic [2:0]  reg_data_source;
  logic        reg_write, reg_direction, mem_read, mem_write, select_super_reg;
  logic        branch_ready, branch_not_zero, branch_lut_set;
  logic [2:0]  branch_index, branch_lut_index;
  logic        done, illegal;
  logic [15:0] retired;

  logic        s_in_ready, s_out_valid;
  logic [3:0]  s_alu_opcode;
  logic [2:0]  s_rs, s_rt;
  logic [7:0]  s_immediate;
  logic [2:0]  s_reg_data_source;
  logic        s_reg_write, s_reg_direction, s_mem_read, s_mem_write, s_select_super_reg;
  logic        s_branch_ready, s_branch_not_zero, s_branch_lut_set;
  logic [2:0]  s_branch_index, s_branch_lut_index;
  logic        s_done, s_illegal;
  logic [1:0]  s_retired;

  always #5 clk = ~clk;

  decode_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_opcode(alu_opcode), .rs(rs), .rt(rt), .immediate(immediate),
    .reg_data_source(reg_data_source), .reg_write(reg_write),
    .reg_direction(reg_direction), .mem_read(mem_read), .mem_write(mem_write),
    .select_super_reg(select_super_reg), .branch_ready(branch_ready),
    .branch_not_zero(branch_not_zero), .branch_lut_set(branch_lut_set),
    .branch_index(branch_index), .branch_lut_index(branch_lut_index),
    .done(done), .illegal(illegal), .retired(retired)
  );

  decode_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .out_valid(s_out_valid), .out_ready(out_ready),
    .alu_opcode(s_alu_opcode), .rs(s_rs), .rt(s_rt), .immediate(s_immediate),
    .reg_data_source(s_reg_data_source), .reg_write(s_reg_write),
    .reg_direction(s_reg_direction), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .select_super_reg(s_select_super_reg), .branch_ready(s_branch_ready),
    .branch_not_zero(s_branch_not_zero), .branch_lut_set(s_branch_lut_set),
    .branch_index(s_branch_index), .branch_lut_index(s_branch_lut_index),
    .done(s_done), .illegal(s_illegal), .retired(s_retired)
  );

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm;
    logic [2:0] src;
    logic [7:0] fl;   // wr dir mr mw sel br bnz bls
    logic [2:0] bidx;
    logic [2:0] blidx;
    logic [1:0] di;   // done illegal
  } bnd_t;

  typedef struct packed {
    logic [8:0] instr;
    bnd_t       exp;
  } vec_t;

  bnd_t act;
  assign act = {alu_opcode, rs, rt, immediate, reg_data_source,
                reg_write, reg_direction, mem_read, mem_write, select_super_reg,
                branch_ready, branch_not_zero, branch_lut_set,
                branch_index, branch_lut_index, done, illegal};

  int   checks;
  int   errors;
  int   exp_ret;
  vec_t vecs[18];
  bnd_t done_bnd;

  function automatic vec_t mkv(input logic [8:0] i, input logic [3:0] alu,
                               input logic [2:0] rsv, input logic [2:0] rtv,
                               input logic [7:0] imm, input logic [2:0] src,
                               input logic [7:0] fl, input logic [2:0] bidx,
                               input logic [2:0] blidx, input logic [1:0] di);
    vec_t v;
    v.instr = i;
    v.exp   = {alu, rsv, rtv, imm, src, fl, bidx, blidx, di};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pair(input logic [8:0] a, input logic [8:0] b,
                          output int bubbles, output bit ok);
    bit acc;
    step();
    in_valid = 1'b1;
    in_instr = a;
    step();
    in_instr = b;
    bubbles  = 0;
    ok       = 1'b0;
    acc      = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid && !mem_read) begin
        ok = 1'b1;
        break;
      end
      if (!out_valid) bubbles++;
      if (in_valid && in_ready) acc = 1'b1;
      step();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    int  nb;
    bit  ok;
    logic [8:0] pa [5];
    logic [8:0] pb [5];
    int  pe [5];

    checks = 0;
    errors = 0;
    vecs[0]  = mkv(9'h02A, 4'd5,  3'd0, 3'd2, 8'h00, 3'd1, 8'b11001000, 3'd0, 3'd0, 2'b00);
    vecs[1]  = mkv(9'h003, 4'd0,  3'd0, 3'd3, 8'h00, 3'd1, 8'b10001000, 3'd0, 3'd0, 2'b00);
    vecs[2]  = mkv(9'h07D, 4'd15, 3'd0, 3'd5, 8'h00, 3'd1, 8'b11001000, 3'd0, 3'd0, 2'b00);
    vecs[3]  = mkv(9'h040, 4'd8,  3'd0, 3'd0, 8'h00, 3'd1, 8'b10001000, 3'd0, 3'd0, 2'b00);
    vecs[4]  = mkv(9'h1D5, 4'd0,  3'd0, 3'd0, 8'h55, 3'd3, 8'b10000000, 3'd0, 3'd0, 2'b00);
    vecs[5]  = mkv(9'h135, 4'd0,  3'd2, 3'd0, 8'h00, 3'd0, 8'b00000110, 3'd5, 3'd0, 2'b00);
    vecs[6]  = mkv(9'h114, 4'd0,  3'd2, 3'd0, 8'h00, 3'd0, 8'b00000100, 3'd4, 3'd0, 2'b00);
    vecs[7]  = mkv(9'h099, 4'd0,  3'd1, 3'd3, 8'h00, 3'd2, 8'b11100000, 3'd0, 3'd0, 2'b00);
    vecs[8]  = mkv(9'h0EE, 4'd0,  3'd6, 3'd5, 8'h00, 3'd0, 8'b00010000, 3'd0, 3'd0, 2'b00);
    vecs[9]  = mkv(9'h140, 4'd0,  3'd0, 3'd0, 8'h00, 3'd0, 8'b10000000, 3'd0, 3'd0, 2'b00);
    vecs[10] = mkv(9'h14B, 4'd0,  3'd0, 3'd3, 8'h00, 3'd0, 8'b11000000, 3'd0, 3'd0, 2'b00);
    vecs[11] = mkv(9'h154, 4'd1,  3'd0, 3'd4, 8'h00, 3'd1, 8'b10000000, 3'd0, 3'd0, 2'b00);
    vecs[12] = mkv(9'h15E, 4'd0,  3'd0, 3'd6, 8'h00, 3'd1, 8'b11000000, 3'd0, 3'd0, 2'b00);
    vecs[13] = mkv(9'h160, 4'd0,  3'd0, 3'd0, 8'h00, 3'd4, 8'b10000000, 3'd0, 3'd0, 2'b00);
    vecs[14] = mkv(9'h177, 4'd0,  3'd0, 3'd0, 8'h00, 3'd0, 8'b00000001, 3'd0, 3'd7, 2'b00);
    vecs[15] = mkv(9'h178, 4'd0,  3'd0, 3'd0, 8'h00, 3'd0, 8'b00000000, 3'd0, 3'd0, 2'b01);
    vecs[16] = mkv(9'h17F, 4'd0,  3'd0, 3'd0, 8'h00, 3'd0, 8'b00000000, 3'd0, 3'd0, 2'b01);
    vecs[17] = mkv(9'h1FF, 4'd0,  3'd0, 3'd0, 8'h7F, 3'd3, 8'b10000000, 3'd0, 3'd0, 2'b00);
    done_bnd = {4'd0, 3'd0, 3'd0, 8'h00, 3'd0, 8'b00000000, 3'd0, 3'd0, 2'b10};

    pa[0] = 9'h099; pb[0] = 9'h00B; pe[0] = 1;
    pa[1] = 9'h099; pb[1] = 9'h00A; pe[1] = 0;
    pa[2] = 9'h099; pb[2] = 9'h0D8; pe[2] = 1;
    pa[3] = 9'h099; pb[3] = 9'h118; pe[3] = 1;
    pa[4] = 9'h099; pb[4] = 9'h10C; pe[4] = 0;

    // reset held two edges with a valid instruction offered
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 9'h1D5; out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_retired", retired, 0);
    chk("rst_bundle", act, 0);
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // back-to-back stream
    step();
    in_valid = 1'b1; in_instr = 9'h02A;
    step();
    in_instr = 9'h1D5;
    @(negedge clk);
    chk("stream0_valid", out_valid, 1);
    chk("stream0_bundle", act, vecs[0].exp);
    chk("stream0_in_ready", in_ready, 1);
    step();
    in_instr = 9'h135;
    @(negedge clk);
    chk("stream1_bundle", act, vecs[4].exp);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream2_valid", out_valid, 1);
    chk("stream2_bundle", act, vecs[5].exp);
    step();
    @(negedge clk);
    chk("stream_retired", retired, 3);
    chk("stream_drained", out_valid, 0);
    exp_ret = 3;

    // decode table, one instruction at a time
    for (int i = 0; i < 18; i++) begin
      step();
      in_valid = 1'b1; in_instr = vecs[i].instr;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_bundle_%03h", i, vecs[i].instr), act, vecs[i].exp);
      step();
      exp_ret++;
      @(negedge clk);
      chk($sformatf("vec%0d_retired", i), retired, exp_ret);
    end

    // load-use interlock
    for (int p = 0; p < 5; p++) begin
      run_pair(pa[p], pb[p], nb, ok);
      exp_ret += 2;
      chk($sformatf("bubbles_%03h_%03h", pa[p], pb[p]), ok ? nb : 99, pe[p]);
    end
    @(negedge clk);
    chk("loaduse_retired", retired, exp_ret);

    // backpressure, then simultaneous retire and accept
    step();
    in_valid = 1'b1; in_instr = 9'h1D5;
    step();
    out_ready = 1'b0; in_instr = 9'h02A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), out_valid, 1);
      chk($sformatf("bp%0d_bundle", k), act, vecs[4].exp);
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
      chk($sformatf("bp%0d_retired", k), retired, exp_ret);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    exp_ret++;
    @(negedge clk);
    chk("bp_swap_valid", out_valid, 1);
    chk("bp_swap_bundle", act, vecs[0].exp);
    chk("bp_swap_retired", retired, exp_ret);
    step();

    // counter saturation on the narrow instance
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_instr = 9'h1D5;
    repeat (5) step();
    in_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("cnt_wide_retired", retired, 5);
    chk("cnt_sat_retired", s_retired, 3);
    exp_ret = 5;

    // halt is sticky and blocks intake
    step();
    in_valid = 1'b1; in_instr = 9'h168;
    step();
    in_instr = 9'h1D5;
    @(negedge clk);
    chk("done_valid", out_valid, 1);
    chk("done_bundle", act, done_bnd);
    chk("done_in_ready", in_ready, 0);
    step();
    exp_ret++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("halt%0d_done", k), done, 1);
      chk($sformatf("halt%0d_valid", k), out_valid, 0);
      chk($sformatf("halt%0d_in_ready", k), in_ready, 0);
      chk($sformatf("halt%0d_retired", k), retired, exp_ret);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("halt_rst_done", done, 0);
    chk("halt_rst_retired", retired, 0);
    chk("halt_rst_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
